match_collect: RTL

MATCH_COLLECT -- requirements
Module: match_collect

---
 rtl/match_collect_pkg.sv | 13 +
 rtl/config.vh | 18 +
 rtl/match_collect_res_fifo2.sv | 49 ++++
 rtl/match_collect.sv | 115 +++++++++++
 4 files changed

// File: rtl/match_collect_pkg.sv
// Shared constants and helpers for the match_collect block.
`include "config.vh"

package match_collect_pkg;

   localparam int unsigned DEF_SCORE_W = `CFG_SCORE_W;

   // Index width that stays legal for a loop length of 1.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/config.vh
// Build configuration for match_collect: frame geometry and score width.
// Define CFG_MATCH_THRESH_EN to add the match_thr input and res_hit output.
`ifndef MATCH_COLLECT_CONFIG_VH
`define MATCH_COLLECT_CONFIG_VH

`ifndef CFG_IMG_VEC_NUM
`define CFG_IMG_VEC_NUM 2
`endif

`ifndef CFG_LIB_VEC_NUM
`define CFG_LIB_VEC_NUM 4
`endif

`ifndef CFG_SCORE_W
`define CFG_SCORE_W 16
`endif

`endif

// File: rtl/match_collect_res_fifo2.sv
// Two-entry result FIFO with first-word-fall-through head; parameterised by data width.
module res_fifo2 #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             valid,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == 2'd2);
   assign valid   = (count != 2'd0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && valid;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push_ok) wr_ptr <= ~wr_ptr;
         if (pop_ok)  rd_ptr <= ~rd_ptr;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is not reset; count gates every read, so stale data is never visible.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/match_collect.sv
// Collects per-line best matches from a score stream into a 2-entry result FIFO.
// Optional threshold hit flag is enabled by defining CFG_MATCH_THRESH_EN.
`include "config.vh"

module match_collect
   import match_collect_pkg::*;
#(
   parameter int unsigned IMG_VEC_N = `CFG_IMG_VEC_NUM,
   parameter int unsigned LIB_VEC_N = `CFG_LIB_VEC_NUM,
   parameter int unsigned SCORE_W   = DEF_SCORE_W
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [SCORE_W-1:0]             in_score,
   input  logic                           in_linefeed,
`ifdef CFG_MATCH_THRESH_EN
   input  logic [SCORE_W-1:0]             match_thr,
   output logic                           res_hit,
`endif
   output logic                           res_valid,
   input  logic                           res_ready,
   output logic [idx_w(IMG_VEC_N)-1:0]    res_img_idx,
   output logic [idx_w(LIB_VEC_N)-1:0]    res_lib_idx,
   output logic [SCORE_W-1:0]             res_score,
   output logic                           done,
   output logic                           err
);

   localparam int unsigned IMG_W = idx_w(IMG_VEC_N);
   localparam int unsigned LIB_W = idx_w(LIB_VEC_N);
`ifdef CFG_MATCH_THRESH_EN
   localparam int unsigned HIT_W = 1;
`else
   localparam int unsigned HIT_W = 0;
`endif
   localparam int unsigned ENTRY_W = HIT_W + IMG_W + LIB_W + SCORE_W;

   logic [LIB_W-1:0]   lib_cnt;
   logic [IMG_W-1:0]   img_cnt;
   logic [LIB_W-1:0]   idx;
   logic [SCORE_W-1:0] max_score;
   logic [LIB_W-1:0]   line_idx;
   logic [SCORE_W-1:0] line_max;
   logic               accept;
   logic               is_last;
   logic               push;
   logic               pop;
   logic               fifo_full;
   logic [ENTRY_W-1:0] push_data;
   logic [ENTRY_W-1:0] head;

   assign in_ready = !fifo_full;
   assign accept   = in_valid && in_ready;
   assign is_last  = (lib_cnt == LIB_W'(LIB_VEC_N - 1));
   assign push     = accept && is_last;
   assign pop      = res_valid && res_ready;
   assign done     = pop && (res_img_idx == IMG_W'(IMG_VEC_N - 1));

   // Strictly-greater compare keeps the lowest index on ties; first beat of a line always loads.
   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      line_max = max_score;
      line_idx = idx;
      if (lib_cnt == '0 || in_score > max_score) begin
         line_max = in_score;
         line_idx = lib_cnt;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lib_cnt   <= '0;
         img_cnt   <= '0;
         idx       <= '0;
         max_score <= '0;
         err       <= 1'b0;
      end else if (accept) begin
         max_score <= line_max;
         idx       <= line_idx;
         if (in_linefeed != is_last) err <= 1'b1;
         if (is_last) begin
            lib_cnt <= '0;
            img_cnt <= (img_cnt == IMG_W'(IMG_VEC_N - 1)) ? '0 : img_cnt + IMG_W'(1);
         end else begin
            lib_cnt <= lib_cnt + LIB_W'(1);
         end
      end
   end

`ifdef CFG_MATCH_THRESH_EN
   assign push_data = {(line_max >= match_thr), img_cnt, line_idx, line_max};
   assign {res_hit, res_img_idx, res_lib_idx, res_score} = head;
`else
   // Without a threshold every result counts as a hit, so no flag is stored.
   assign push_data = {img_cnt, line_idx, line_max};
   assign {res_img_idx, res_lib_idx, res_score} = head;
`endif

   res_fifo2 #(
      .WIDTH(ENTRY_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .full      (fifo_full),
      .valid     (res_valid),
      .head      (head)
   );

endmodule
